bus_burst_master: RTL

//  Synthesizable command-driven burst master for the switch req/valid/ready/last bus.

---
 rtl/bus_burst_master.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_burst_master                                                         |
// | Command-driven write/read burst generator with read-data pattern check.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus_burst_master #(
    parameter int AW        = 12,
    parameter int DW        = 14,
    parameter int SW        = 4,
    parameter int LW        = 8,
    parameter int EW        = 8,
    parameter int ADDR_STEP = 4,
    parameter int WRAP_SIZE = 64,
    parameter int PAT_INC   = 1
) (
    input  logic          iClk,
    input  logic          iRst_n,

    input  logic          iCmdValid,
    output logic          oCmdReady,
    input  logic          iCmdWrite,
    input  logic [AW-1:0] iCmdAddr,
    input  logic [SW-1:0] iCmdSel,
    input  logic [LW-1:0] iCmdLen,
    input  logic [1:0]    iCmdMode,
    input  logic [3:0]    iCmdGap,
    input  logic [DW-1:0] iCmdSeed,

    output logic          oMstWrReq,
    output logic          oMstWrValid,
    output logic          oMstWrLast,
    output logic [AW-1:0] oMstWrAddr,
    output logic [SW-1:0] oMstWrSel,
    output logic [DW-1:0] oMstWrData,
    input  logic          iMstWrReady,

    output logic          oMstRdReq,
    output logic          oMstRdValid,
    output logic          oMstRdLast,
    output logic [AW-1:0] oMstRdAddr,
    output logic [SW-1:0] oMstRdSel,
    input  logic          iMstRdReady,
    input  logic [DW-1:0] iMstRdData,

    output logic [DW-1:0] oRdData,
    output logic          oRdDataValid,
    output logic [EW-1:0] oErrCnt,
    output logic [AW-1:0] oFirstErrAddr,
    output logic          oBusy,
    output logic          oDone
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0]    c_mode_fixed = 2'b01;
    localparam logic [1:0]    c_mode_wrap  = 2'b10;
    localparam logic [AW-1:0] c_addr_step  = AW'(ADDR_STEP);
    localparam logic [AW-1:0] c_wrap_mask  = AW'(WRAP_SIZE - 1);
    localparam logic [DW-1:0] c_pat_inc    = DW'(PAT_INC);
    localparam logic [EW-1:0] c_err_max    = '1;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;

    logic          r_write;
    logic [SW-1:0] r_sel;
    logic [LW-1:0] r_len;
    logic [1:0]    r_mode;
    logic [3:0]    r_gap;
    logic [LW-1:0] r_beat;
    logic [3:0]    r_gap_cnt;
    logic [AW-1:0] r_cur_addr;
    logic [DW-1:0] r_cur_data;

    logic          r_cap_pend;
    logic [AW-1:0] r_cap_addr;
    logic [DW-1:0] r_cap_exp;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic [EW-1:0] r_err_cnt;
    logic [AW-1:0] r_first_err_addr;

    logic          w_cmd_acc;
    logic          w_beat_ready;
    logic          w_beat_acc;
    logic          w_last;
    logic          w_rd_mismatch;
    logic [AW-1:0] w_incr_addr;
    logic [AW-1:0] w_next_addr;

    assign w_cmd_acc     = iCmdValid && (r_state == S_IDLE);
    assign w_beat_ready  = r_write ? iMstWrReady : iMstRdReady;
    assign w_beat_acc    = (r_state == S_BEAT) && w_beat_ready;
    assign w_last        = (r_beat == r_len);
    assign w_rd_mismatch = r_cap_pend && (iMstRdData != r_cap_exp);

    // Running address: WRAP keeps the window base and wraps only the low bits,
    // which equals the closed-form base | ((start + n*step) & mask).
    always_comb begin
        w_incr_addr = r_cur_addr + c_addr_step;
        case (r_mode)
            c_mode_fixed: w_next_addr = r_cur_addr;
            c_mode_wrap:  w_next_addr = (r_cur_addr & ~c_wrap_mask) | (w_incr_addr & c_wrap_mask);
            default:      w_next_addr = w_incr_addr;
        endcase
    end

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    w_next_state = S_BEAT;
                end
            end
            S_BEAT: begin
                if (w_beat_acc) begin
                    if (w_last) begin
                        w_next_state = r_write ? S_DONE : S_DRAIN;
                    end else if (r_gap != 4'd0) begin
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next_state = S_BEAT;
                end
            end
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command latch and beat sequencing
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_write    <= 1'b0;
            r_sel      <= '0;
            r_len      <= '0;
            r_mode     <= 2'b00;
            r_gap      <= 4'd0;
            r_beat     <= '0;
            r_gap_cnt  <= 4'd0;
            r_cur_addr <= '1;
            r_cur_data <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_write    <= iCmdWrite;
                r_sel      <= iCmdSel;
                r_len      <= iCmdLen;
                r_mode     <= iCmdMode;
                r_gap      <= iCmdGap;
                r_beat     <= '0;
                r_cur_addr <= iCmdAddr;
                r_cur_data <= iCmdSeed;
            end else if (w_beat_acc && !w_last) begin
                r_beat     <= r_beat + 1'b1;
                r_cur_addr <= w_next_addr;
                r_cur_data <= r_cur_data + c_pat_inc;
                r_gap_cnt  <= r_gap - 4'd1;
            end else if (r_state == S_GAP) begin
                r_gap_cnt  <= r_gap_cnt - 4'd1;
            end
        end
    end

    // Read return path: the beat accepted at one edge returns its data at the
    // next edge, so the expected value and address travel one stage behind.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cap_pend       <= 1'b0;
            r_cap_addr       <= '0;
            r_cap_exp        <= '0;
            r_rd_data        <= '0;
            r_rd_valid       <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_cap_pend <= w_beat_acc && !r_write;
            r_rd_valid <= r_cap_pend;
            if (w_beat_acc) begin
                r_cap_addr <= r_cur_addr;
                r_cap_exp  <= r_cur_data;
            end
            if (r_cap_pend) begin
                r_rd_data <= iMstRdData;
            end
            if (w_cmd_acc) begin
                r_err_cnt        <= '0;
                r_first_err_addr <= '0;
            end else if (w_rd_mismatch) begin
                if (r_err_cnt == '0) begin
                    r_first_err_addr <= r_cap_addr;
                end
                if (r_err_cnt != c_err_max) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    // Output decode: only the channel selected by the command is driven
    always_comb begin
        oMstWrReq     = 1'b0;
        oMstWrValid   = 1'b0;
        oMstWrLast    = 1'b0;
        oMstWrAddr    = '1;
        oMstWrSel     = '0;
        oMstWrData    = '0;
        oMstRdReq     = 1'b0;
        oMstRdValid   = 1'b0;
        oMstRdLast    = 1'b0;
        oMstRdAddr    = '1;
        oMstRdSel     = '0;
        oCmdReady     = (r_state == S_IDLE);
        oBusy         = (r_state != S_IDLE);
        oDone         = (r_state == S_DONE);
        oRdData       = r_rd_data;
        oRdDataValid  = r_rd_valid;
        oErrCnt       = r_err_cnt;
        oFirstErrAddr = r_first_err_addr;
        if ((r_state == S_BEAT) || (r_state == S_GAP)) begin
            if (r_write) begin
                oMstWrReq   = 1'b1;
                oMstWrValid = (r_state == S_BEAT);
                oMstWrLast  = (r_state == S_BEAT) && w_last;
                oMstWrAddr  = r_cur_addr;
                oMstWrSel   = r_sel;
                oMstWrData  = r_cur_data;
            end else begin
                oMstRdReq   = 1'b1;
                oMstRdValid = (r_state == S_BEAT);
                oMstRdLast  = (r_state == S_BEAT) && w_last;
                oMstRdAddr  = r_cur_addr;
                oMstRdSel   = r_sel;
            end
        end
    end

endmodule
`default_nettype wire
